// File: rtl/sipo_deframer_pkg.sv
// sipo_deframer_pkg
//   Definitions shared by the serial-in/parallel-out deframer and its
//   upstream 10-bit shifter partner.
//   - SIPO_WIDTH : default word width, must match the upstream shifter.
//   - state_e    : deframer FSM state (HUNT = waiting for SOF, SHIFT = mid-word).
package sipo_deframer_pkg;

  localparam int unsigned SIPO_WIDTH = 10;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage : sipo_deframer_pkg

// File: rtl/sipo_deframer_if.sv
// sipo_deframer_if
//   Serial input side and valid/ready word output side of the deframer.
//   Signals:
//     SI, SI_VALID, SOF  serial bit, bit qualifier, start-of-frame marker
//     O, O_VALID         assembled word and its valid flag
//     O_READY            consumer accepts O when O_VALID && O_READY
//     BUSY               a word is partially assembled
//     OVERRUN            pulse: completed word dropped, holding register full
//     FRAME_ERR          pulse: SOF mid-word, partial word discarded
//   Modports:
//     master : the environment (serial source + word consumer)
//     slave  : the deframer itself
interface sipo_deframer_if
  import sipo_deframer_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_WIDTH
);

  logic             SI;
  logic             SI_VALID;
  logic             SOF;
  logic [WIDTH-1:0] O;
  logic             O_VALID;
  logic             O_READY;
  logic             BUSY;
  logic             OVERRUN;
  logic             FRAME_ERR;

  modport master (
    output SI, SI_VALID, SOF, O_READY,
    input  O, O_VALID, BUSY, OVERRUN, FRAME_ERR
  );

  modport slave (
    input  SI, SI_VALID, SOF, O_READY,
    output O, O_VALID, BUSY, OVERRUN, FRAME_ERR
  );

endinterface : sipo_deframer_if

// File: rtl/sipo_hold_reg.sv
// sipo_hold_reg
//   One-word output holding register with valid/ready handshake.
//   A load is accepted when the register is empty or is being drained in
//   the same cycle; otherwise the incoming word is dropped and overrun_o
//   pulses for one cycle. Draining clears valid but keeps the data.
//   Ports:
//     clk_i, rst_ni  clock, asynchronous active-low reset
//     load_i         a completed word is offered this cycle
//     data_i         the completed word
//     ready_i        consumer accepts data_o when valid_o
//     data_o         held word (registered)
//     valid_o        data_o holds an unconsumed word (registered)
//     overrun_o      one-cycle pulse: offered word was dropped (registered)
module sipo_hold_reg
  import sipo_deframer_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             accept;

  // Space is available if empty, or if the current word leaves this cycle.
  assign accept = !valid_q || ready_i;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load_i) begin
      if (accept) begin
        data_d  = data_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule : sipo_hold_reg

// File: rtl/sipo_deframer.sv
// sipo_deframer
//   Rebuilds WIDTH-bit words from an MSB-first serial stream framed by SOF
//   and presents them through a one-word valid/ready holding register.
//   Ports:
//     CLK          system clock, rising edge
//     ASYNCRESETN  asynchronous active-low reset
//     bus          sipo_deframer_if.slave: SI/SI_VALID/SOF in, O/O_VALID out,
//                  O_READY in, BUSY/OVERRUN/FRAME_ERR status out
//   All outputs are driven from registers; no input reaches an output
//   combinationally.
module sipo_deframer
  import sipo_deframer_pkg::*;
#(
  parameter int unsigned WIDTH = SIPO_WIDTH
) (
  input  logic           CLK,
  input  logic           ASYNCRESETN,
  sipo_deframer_if.slave bus
);

  localparam int unsigned    CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q;
  // Only the WIDTH-1 most recent bits are ever used: the WIDTH-th bit is
  // taken straight from SI on the completing edge.
  logic [WIDTH-2:0]   shreg_q;
  logic [CNT_W-1:0]   count_q;
  logic               frame_err_q;

  logic [WIDTH-1:0]   word;
  logic               load;

  assign word = {shreg_q, bus.SI};

  // A plain (non-SOF) bit at count WIDTH-1 completes the word; a completing
  // bit with SOF is a restart instead.
  assign load = (state_q == SHIFT) && bus.SI_VALID && !bus.SOF && (count_q == LAST);

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q     <= HUNT;
      shreg_q     <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (bus.SI_VALID) begin
        unique case (state_q)
          HUNT: begin
            if (bus.SOF) begin
              shreg_q <= word[WIDTH-2:0];
              count_q <= CNT_W'(1);
              state_q <= SHIFT;
            end
          end
          SHIFT: begin
            shreg_q <= word[WIDTH-2:0];
            if (bus.SOF) begin
              count_q     <= CNT_W'(1);
              frame_err_q <= 1'b1;
            end else if (count_q == LAST) begin
              count_q <= '0;
              state_q <= HUNT;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign bus.BUSY      = (state_q == SHIFT);
  assign bus.FRAME_ERR = frame_err_q;

  sipo_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk_i     (CLK),
    .rst_ni    (ASYNCRESETN),
    .load_i    (load),
    .data_i    (word),
    .ready_i   (bus.O_READY),
    .data_o    (bus.O),
    .valid_o   (bus.O_VALID),
    .overrun_o (bus.OVERRUN)
  );

endmodule : sipo_deframer
